// File: rtl/sdio_blkreader.sv
// rtl/sdio_blkreader.sv - Wishbone master that fetches one SD/eMMC block per request into a stream
//
// Sequence per request: write sector to ADDR_ARG, write CMD_WORD to ADDR_CMD,
// poll ADDR_CMD until BUSY_BIT clears (ERR_BIT aborts), then read ADDR_FIFO
// 2^LGBLK times, pushing each word out on the valid/ready stream.
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_start, i_sector       request pulse (taken only when idle) and sector number
//   o_busy                  high whenever not idle
//   o_done, o_err           one-cycle completion pulse; o_err qualifies failure
//   o_wb_cyc/stb/we/addr/data/sel, i_wb_stall/ack/data
//                           Wishbone master towards the controller register port
//   o_valid, i_ready, o_data, o_last
//                           output word stream; o_last marks the block's final word
//
// Build option: define SDIO_BLKREADER_TIMEOUT_EN to abandon polling after
// 2^LGTIMEOUT cycles in POLL with an error completion.

module sdio_blkreader #(
    parameter int            MW        = 32,
    parameter int            LGBLK     = 7,
    parameter logic [2:0]    ADDR_CMD  = 3'd0,
    parameter logic [2:0]    ADDR_ARG  = 3'd1,
    parameter logic [2:0]    ADDR_FIFO = 3'd2,
    parameter logic [MW-1:0] CMD_WORD  = 'h0000_0951,
    parameter int            BUSY_BIT  = 14,
    parameter int            ERR_BIT   = 15,
    parameter int            LGTIMEOUT = 20
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_start,
    input  logic [31:0]     i_sector,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [2:0]      o_wb_addr,
    output logic [MW-1:0]   o_wb_data,
    output logic [MW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic [MW-1:0]   i_wb_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [MW-1:0]   o_data,
    output logic            o_last
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ARG  = 3'd1,
        S_WR_CMD  = 3'd2,
        S_POLL    = 3'd3,
        S_RD_FIFO = 3'd4,
        S_PUSH    = 3'd5
    } state_t;

    localparam logic [LGBLK:0] LAST_IDX = {1'b0, {LGBLK{1'b1}}};

    state_t          state;
    state_t          state_next;
    logic [31:0]     sector;
    logic [LGBLK:0]  word_cnt;

    logic            bus_ack;
    logic            launch;
    logic            take;
    logic            finish;
    logic            finish_err;
    logic            tmo_hit;
    logic            req_we;
    logic [2:0]      req_addr;
    logic [MW-1:0]   req_data;

    assign o_busy   = (state != S_IDLE);
    assign o_wb_sel = {(MW/8){o_wb_stb}};

`ifdef SDIO_BLKREADER_TIMEOUT_EN
    // Held at zero outside POLL, so it restarts from zero on every POLL entry.
    logic [LGTIMEOUT-1:0] tmo_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo_cnt <= '0;
        end else if (state != S_POLL) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + LGTIMEOUT'(1);
        end
    end

    assign tmo_hit = (state == S_POLL) && (&tmo_cnt);
`else
    assign tmo_hit = 1'b0;

    // LGTIMEOUT only sizes the optional timeout counter.
    if (LGTIMEOUT < 1) begin : g_no_timeout
    end
`endif

    // Next state plus single-cycle control strobes for the register process.
    always_comb begin
        state_next = state;
        bus_ack    = o_wb_cyc && i_wb_ack;     // stray acks with no cycle open are ignored
        take       = o_valid && i_ready;
        launch     = 1'b0;
        finish     = 1'b0;
        finish_err = 1'b0;
        req_we     = 1'b0;
        req_addr   = ADDR_CMD;
        req_data   = '0;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_next = S_WR_ARG;
                end
            end

            S_WR_ARG: begin
                // cyc is always low on the first cycle of a bus state, which
                // both starts the request and guarantees the one-cycle gap.
                launch   = !o_wb_cyc;
                req_we   = 1'b1;
                req_addr = ADDR_ARG;
                req_data = MW'(sector);
                if (bus_ack) begin
                    state_next = S_WR_CMD;
                end
            end

            S_WR_CMD: begin
                launch   = !o_wb_cyc;
                req_we   = 1'b1;
                req_addr = ADDR_CMD;
                req_data = CMD_WORD;
                if (bus_ack) begin
                    state_next = S_POLL;
                end
            end

            S_POLL: begin
                launch   = !o_wb_cyc;
                req_addr = ADDR_CMD;
                if (tmo_hit) begin
                    launch     = 1'b0;
                    state_next = S_IDLE;
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (bus_ack) begin
                    if (i_wb_data[ERR_BIT]) begin
                        state_next = S_IDLE;
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end else if (!i_wb_data[BUSY_BIT]) begin
                        state_next = S_RD_FIFO;
                    end
                end
            end

            S_RD_FIFO: begin
                launch   = !o_wb_cyc;
                req_addr = ADDR_FIFO;
                if (bus_ack) begin
                    state_next = S_PUSH;
                end
            end

            S_PUSH: begin
                if (take) begin
                    if (o_last) begin
                        state_next = S_IDLE;
                        finish     = 1'b1;
                    end else begin
                        state_next = S_RD_FIFO;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= S_IDLE;
            sector    <= '0;
            word_cnt  <= '0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_addr <= '0;
            o_wb_data <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_last    <= 1'b0;
        end else begin
            state  <= state_next;
            o_done <= finish;
            o_err  <= finish_err;

            if (state == S_IDLE && i_start) begin
                sector   <= i_sector;
                word_cnt <= '0;
            end

            if (launch) begin
                o_wb_cyc  <= 1'b1;
                o_wb_stb  <= 1'b1;
                o_wb_we   <= req_we;
                o_wb_addr <= req_addr;
                o_wb_data <= req_data;
            end else if (bus_ack || tmo_hit) begin
                // An ack ends the cycle even if the slave acked a stalled stb.
                o_wb_cyc <= 1'b0;
                o_wb_stb <= 1'b0;
            end else if (o_wb_stb && !i_wb_stall) begin
                o_wb_stb <= 1'b0;
            end

            if (bus_ack && state == S_RD_FIFO) begin
                o_data  <= i_wb_data;
                o_last  <= (word_cnt == LAST_IDX);
                o_valid <= 1'b1;
            end else if (take) begin
                o_valid  <= 1'b0;
                o_last   <= 1'b0;
                word_cnt <= word_cnt + (LGBLK+1)'(1);
            end
        end
    end

endmodule
